// File: rtl/shift_popcount.sv
// rtl/shift_popcount.sv - chunked ones/zeros counter, whole-word or trailing-run mode
module shift_popcount #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic             ready,
    output logic             done,
    output logic [CW-1:0]    k
);

    localparam int NCH = WIDTH / STEP;
    localparam int NW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr;
    logic [1:0]       mode_q;
    logic [NW-1:0]    cnt;
    logic [STEP-1:0]  chunk;
    logic [CW-1:0]    ones, run;
    logic             alive, last;

    assign ready = (state == IDLE);

    always_comb begin
        chunk = sr[STEP-1:0] ^ {STEP{mode_q[0]}};
        ones  = '0;
        run   = '0;
        alive = 1'b1;
        // run keeps counting only while every lower bit of the chunk matched
        for (int i = 0; i < STEP; i++) begin
            ones  = ones + CW'(chunk[i]);
            alive = alive & chunk[i];
            run   = run + CW'(alive);
        end
        last = (cnt == NW'(NCH - 1)) || (mode_q[1] && !(&chunk));
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            mode_q <= '0;
            cnt    <= '0;
            k      <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr     <= d;
                        mode_q <= mode;
                        k      <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    k   <= k + (mode_q[1] ? run : ones);
                    sr  <= sr >> STEP;
                    cnt <= cnt + NW'(1);
                    if (last) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_popcount.md
SHIFT_POPCOUNT -- requirements
Module: shift_popcount

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 2..64.
REQ-002 Parameter STEP, default 1: bits examined per RUN cycle; legal range 1..WIDTH; WIDTH % STEP == 0; other values are illegal and need not be detected.
REQ-003 Derived constant CW = $clog2(WIDTH+1): result width.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only when ready=1.
REQ-007 d  input  WIDTH  operand word; captured on start acceptance.
REQ-008 mode  input  2  captured on start acceptance; bit0=1 counts zeros, else ones; bit1=1 counts the trailing run from the LSB only, else counts the whole word.
REQ-009 ready  output  1  high in IDLE.
REQ-010 done  output  1  one-cycle pulse when a result becomes valid.
REQ-011 k  output  CW  result count.

Function
REQ-012 The block SHALL implement two states: IDLE and RUN.
REQ-013 In IDLE with start=1, the block SHALL, on that edge, load d into an internal shift register, latch mode, clear k to 0, clear the chunk counter, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL hold k and all other state unchanged.
REQ-015 Each RUN cycle SHALL examine the low STEP bits of the shift register, each XORed with mode bit0 ("match" = bit value 1 after XOR).
REQ-016 Whole-word mode (mode bit1=0): each RUN cycle SHALL add the number of matching bits in the chunk to k.
REQ-017 Run mode (mode bit1=1): each RUN cycle SHALL add the number of consecutive matching bits in the chunk, counted from the chunk's LSB, to k.
REQ-018 In run mode, a chunk containing a non-matching bit SHALL end the operation in that cycle.
REQ-019 Each RUN cycle SHALL shift the shift register right by STEP and increment the chunk counter.
REQ-020 The operation SHALL end in the RUN cycle that examines chunk WIDTH/STEP-1, if it has not already ended.
REQ-021 On the edge ending the operation, the block SHALL update k with the final value, enter IDLE, and set done=1 for exactly one cycle.
REQ-022 Latency: done SHALL be high in the cycle beginning L edges after the start-accepting edge.
REQ-023 In whole-word mode, L SHALL equal WIDTH/STEP.
REQ-024 In run mode, L SHALL equal the index+1 of the chunk holding the first mismatch, or WIDTH/STEP if there is no mismatch.
REQ-025 ready SHALL be 0 throughout RUN and 1 in IDLE, including the cycle in which done=1.
REQ-026 start SHALL be ignored while in RUN; d and mode changes during RUN SHALL have no effect.
REQ-027 A start asserted in the done cycle SHALL be accepted, giving back-to-back operations with one IDLE cycle between them.
REQ-028 k SHALL never overflow: its maximum is WIDTH, and CW holds WIDTH.
REQ-029 k SHALL hold the last result until the next start acceptance or reset.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL enter IDLE and set ready=1, done=0 and k=0, and clear the shift register, the chunk counter and the latched mode.
REQ-031 Reset SHALL take priority over start and over RUN progress.
REQ-032 Reset during RUN SHALL abort the operation with no done pulse.
REQ-033 The block SHALL accept a start on the first edge with reset=0.

Verification
REQ-034 WIDTH=8, STEP=1, d=8'b1011_0110, mode=00, start pulse -> ready falls, done=1 eight cycles after acceptance, k=5, ready=1.
REQ-035 Same d, mode=01 -> k=3 after 8 cycles; then mode=10 with d=8'b0000_0111 -> k=3, done 4 cycles after acceptance.
REQ-036 WIDTH=8, STEP=1, mode=11, d=8'hFF -> k=0, done 1 cycle after acceptance; mode=10, d=8'hFF -> k=8 after 8 cycles.
REQ-037 WIDTH=16, STEP=4, d=16'hFFFF, mode=00 -> k=16 (5 bits), done after 4 cycles; d=16'h00F7, mode=10 -> k=3, done after 1 cycle.
REQ-038 Start accepted, then start toggled and d changed during RUN, reset at the 3rd RUN cycle -> no done, k=0, ready=1 next cycle; a fresh start with d=8'h01, mode=00 then yields k=1.
REQ-039 Start held high continuously with WIDTH=8, STEP=1 -> an acceptance every 9 cycles, one done pulse per operation, k correct for each operation.
